machine: RTL and testbench
==========================

MACHINE -- requirements
Module: machine

Interface
REQ-001 The module SHALL have these ports:
- clk  input  1  sole clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low; 0 forces the reset state immediately.
- ena  input  1  run enable, sampled only at instruction boundary.
- opcode  input  3  instruction opcode from the instruction register.
- zero  input  1  accumulator-zero flag from the ALU.
- alu_ena  output  1  ALU strobe; the ALU captures on its rising edge.
- rd  output  1  memory read.
- wr  output  1  memory write.
- load_ir  output  1  instruction-register byte load.
- inc_pc  output  1  program-counter increment.
- load_pc  output  1  program-counter load (jump).
- load_acc  output  1  accumulator load from ALU output.
- datactl_ena  output  1  drive accumulator onto data bus.
- halt  output  1  processor halted.
REQ-002 Opcode encoding SHALL be: HLT=000, SKZ=001, ADD=010, ANDD=011, XORR=100, LDA=101, STO=110, JMP=111.

Function
REQ-003 The FSM SHALL have nine states: FETCH_HI, FETCH_LO, IDLE, DECODE, EXEC, MEM, WB, NEXT, HALTED.
REQ-004 Every output SHALL come directly from a flop, be glitch-free, and equal the table value for the current state.
REQ-005 The state sequence SHALL be FETCH_HI->FETCH_LO->IDLE->DECODE->EXEC->MEM->WB->NEXT->FETCH_HI, one clk per state (8 cycles per instruction).
REQ-006 NEXT SHALL be the boundary state: ena=1 goes to FETCH_HI; ena=0 stays in NEXT with all outputs 0.
REQ-007 ena SHALL be ignored in every state other than NEXT.
REQ-008 In DECODE, opcode SHALL be latched into op_q, and op_q alone SHALL govern EXEC, MEM and WB.
REQ-009 In EXEC, zero SHALL be latched into zero_q; later changes of zero SHALL be ignored.
REQ-010 In DECODE with opcode=HLT, the next state SHALL be HALTED.
REQ-011 HALTED SHALL be left only by reset.
REQ-012 Output table (unlisted outputs are 0):
- FETCH_HI: rd, load_ir.
- FETCH_LO: rd, load_ir, inc_pc.
- IDLE: none.
- DECODE: inc_pc if opcode!=HLT; halt if opcode=HLT.
- EXEC: rd for ADD/ANDD/XORR/LDA; datactl_ena for STO.
- MEM: rd and alu_ena for ADD/ANDD/XORR/LDA; datactl_ena and wr for STO; inc_pc if SKZ and zero_q; load_pc for JMP.
- WB: rd and load_acc for ADD/ANDD/XORR/LDA; datactl_ena for STO; inc_pc if SKZ and zero_q; load_pc for JMP.
- NEXT: none.
- HALTED: halt.
REQ-013 alu_ena SHALL be high for exactly one cycle per ALU instruction and low in the preceding cycle, so it forms one clean rising edge.
REQ-014 wr and rd SHALL never be high together.
REQ-015 datactl_ena SHALL cover wr by one cycle on each side.
REQ-016 inc_pc SHALL pulse 2 times per instruction, 4 times for SKZ with zero_q=1, and 0 times once halted.

Reset
REQ-017 reset=0 SHALL force state=NEXT, op_q=000, zero_q=0 and all outputs 0, without a clock edge.
REQ-018 The first rising clk after reset rises with ena=1 SHALL enter FETCH_HI.
REQ-019 Reset asserted mid-instruction (including during wr) SHALL abort the instruction with no further pulses.

Structure
REQ-020 Opcode constants and state encodings (4-bit) SHALL live in a shared package cpu_pkg, which the ALU also uses.
REQ-021 The block SHALL be a single module with no sub-module; the next-state/next-output decode is one combinational process feeding the output flops.

Verification
REQ-022 The bench SHALL cover these scenarios:
- ADD, ena=1 after reset: rd cycles 1,2,5,6,7; inc_pc cycles 2,4; alu_ena cycle 6 only; load_acc cycle 7; rd again cycle 9.
- STO: datactl_ena cycles 5-7; wr cycle 6 only; rd never high with wr.
- SKZ, zero=1 at EXEC then zero=0 at MEM: inc_pc cycles 2,4,6,7 (4 pulses); same with zero=0 at EXEC gives 2 pulses.
- JMP: load_pc cycles 6,7; no inc_pc in cycles 5-8.
- HLT: halt from cycle 4 onward; no rd for 20 further cycles; reset low then high with ena=1 gives rd on the next clk.
- Reset dropped mid-MEM of STO: wr and datactl_ena fall at once, no clk needed; ena=0 after release holds all outputs 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encoding, control-FSM state encoding and the
// bundle of control strobes the FSM drives. The ALU imports this package too.
package cpu_pkg;

   // Instruction opcodes as they sit in the instruction register.
   typedef enum logic [2:0] {
      OP_HLT  = 3'b000,
      OP_SKZ  = 3'b001,
      OP_ADD  = 3'b010,
      OP_ANDD = 3'b011,
      OP_XORR = 3'b100,
      OP_LDA  = 3'b101,
      OP_STO  = 3'b110,
      OP_JMP  = 3'b111
   } opcode_e;

   // Control FSM states; eight run states per instruction plus HALTED.
   typedef enum logic [3:0] {
      S_FETCH_HI = 4'd0,
      S_FETCH_LO = 4'd1,
      S_IDLE     = 4'd2,
      S_DECODE   = 4'd3,
      S_EXEC     = 4'd4,
      S_MEM      = 4'd5,
      S_WB       = 4'd6,
      S_NEXT     = 4'd7,
      S_HALTED   = 4'd8
   } state_e;

   // Control strobes, registered as one word so every output leaves a flop.
   typedef struct packed {
      logic alu_ena;
      logic rd;
      logic wr;
      logic load_ir;
      logic inc_pc;
      logic load_pc;
      logic load_acc;
      logic datactl_ena;
      logic halt;
   } ctl_t;

   // True for instructions that read memory and feed the ALU.
   function automatic logic is_alu_op(input opcode_e op);
      return (op == OP_ADD) || (op == OP_ANDD) || (op == OP_XORR) || (op == OP_LDA);
   endfunction

endpackage

// File: rtl/machine.sv
// Control FSM of the accumulator CPU. Sequences fetch, decode, execute,
// memory and write-back over eight clocks per instruction. Outputs are
// registered: the decode below computes the strobes for the state being
// entered, so each strobe is a clean flop output for the whole state.
module machine
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       ena,
   input  logic [2:0] opcode,
   input  logic       zero,
   output logic       alu_ena,
   output logic       rd,
   output logic       wr,
   output logic       load_ir,
   output logic       inc_pc,
   output logic       load_pc,
   output logic       load_acc,
   output logic       datactl_ena,
   output logic       halt
);

   state_e  state_q, state_d;
   opcode_e op_q, op_d;
   logic    zero_q, zero_d;
   ctl_t    ctl_q, ctl_d;
   opcode_e op_in;

   // Next-state and next-output decode for the state being entered.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      state_d = state_q;
      op_d    = op_q;
      zero_d  = zero_q;
      ctl_d   = '0;
      op_in   = opcode_e'(opcode);

      unique case (state_q)
         S_NEXT: begin
            // Instruction boundary: the only place ena is looked at.
            if (ena) begin
               state_d       = S_FETCH_HI;
               ctl_d.rd      = 1'b1;
               ctl_d.load_ir = 1'b1;
            end
         end
         S_FETCH_HI: begin
            state_d       = S_FETCH_LO;
            ctl_d.rd      = 1'b1;
            ctl_d.load_ir = 1'b1;
            ctl_d.inc_pc  = 1'b1;
         end
         S_FETCH_LO: begin
            state_d = S_IDLE;
         end
         S_IDLE: begin
            // Entering DECODE: the opcode is already in the IR.
            state_d = S_DECODE;
            if (op_in == OP_HLT) ctl_d.halt   = 1'b1;
            else                 ctl_d.inc_pc = 1'b1;
         end
         S_DECODE: begin
            // Capture the opcode; from here on op_q alone steers the instruction.
            op_d = op_in;
            if (op_in == OP_HLT) begin
               state_d    = S_HALTED;
               ctl_d.halt = 1'b1;
            end else begin
               state_d           = S_EXEC;
               ctl_d.rd          = is_alu_op(op_in);
               ctl_d.datactl_ena = (op_in == OP_STO);
            end
         end
         S_EXEC: begin
            // Capture the zero flag; MEM outputs use the value being captured.
            zero_d            = zero;
            state_d           = S_MEM;
            ctl_d.rd          = is_alu_op(op_q);
            ctl_d.alu_ena     = is_alu_op(op_q);
            ctl_d.datactl_ena = (op_q == OP_STO);
            ctl_d.wr          = (op_q == OP_STO);
            ctl_d.inc_pc      = (op_q == OP_SKZ) && zero;
            ctl_d.load_pc     = (op_q == OP_JMP);
         end
         S_MEM: begin
            state_d           = S_WB;
            ctl_d.rd          = is_alu_op(op_q);
            ctl_d.load_acc    = is_alu_op(op_q);
            ctl_d.datactl_ena = (op_q == OP_STO);
            ctl_d.inc_pc      = (op_q == OP_SKZ) && zero_q;
            ctl_d.load_pc     = (op_q == OP_JMP);
         end
         S_WB: begin
            state_d = S_NEXT;
         end
         S_HALTED: begin
            // Only reset leaves this state.
            ctl_d.halt = 1'b1;
         end
         default: begin
            state_d = S_NEXT;
         end
      endcase
   end

   // State, captured operands and output flops.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: reset is asynchronous, so it clears every strobe immediately,
      // aborting an instruction mid-flight without waiting for a clock.
      if (!reset) begin
         state_q <= S_NEXT;
         op_q    <= OP_HLT;
         zero_q  <= 1'b0;
         ctl_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments keep all flops updating together
         // from the values that were present before the edge.
         state_q <= state_d;
         op_q    <= op_d;
         zero_q  <= zero_d;
         ctl_q   <= ctl_d;
      end
   end

   assign alu_ena     = ctl_q.alu_ena;
   assign rd          = ctl_q.rd;
   assign wr          = ctl_q.wr;
   assign load_ir     = ctl_q.load_ir;
   assign inc_pc      = ctl_q.inc_pc;
   assign load_pc     = ctl_q.load_pc;
   assign load_acc    = ctl_q.load_acc;
   assign datactl_ena = ctl_q.datactl_ena;
   assign halt        = ctl_q.halt;

endmodule

// File: tb/tb_machine.sv
// Bench for the CPU control FSM. A driver issues instructions with random
// don't-care inputs and pushes the expected strobe word for every clock into
// a queue; a monitor pops one word per cycle and compares.
// Strobe word order: {alu_ena, rd, wr, load_ir, inc_pc, load_pc, load_acc, datactl_ena, halt}
module tb_machine;
   import cpu_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic ena;
   logic [2:0] opcode;
   logic zero;
   logic alu_ena, rd, wr, load_ir, inc_pc, load_pc, load_acc, datactl_ena, halt;
   logic [8:0] dut_out;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   logic halted = 1'b0;
   logic [8:0] exp_q[$];
   logic [8:0] mon_exp;

   machine dut (
      .clk(clk), .reset(reset), .ena(ena), .opcode(opcode), .zero(zero),
      .alu_ena(alu_ena), .rd(rd), .wr(wr), .load_ir(load_ir), .inc_pc(inc_pc),
      .load_pc(load_pc), .load_acc(load_acc), .datactl_ena(datactl_ena), .halt(halt)
   );

   assign dut_out = {alu_ena, rd, wr, load_ir, inc_pc, load_pc, load_acc, datactl_ena, halt};

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at t=%0t: got %b, expected %b", name, $time, act, exp);
      end
   endtask

   // Expected strobes for cycle c (1..8) of an instruction, written from the
   // per-cycle behaviour of each instruction class.
   function automatic logic [8:0] model(input opcode_e op, input logic zx, input int c);
      logic alu, sto, jmp, hlt, skip;
      logic e_alu, e_rd, e_wr, e_ir, e_inc, e_pc, e_acc, e_dc, e_halt;
      alu  = (op == OP_ADD) || (op == OP_ANDD) || (op == OP_XORR) || (op == OP_LDA);
      sto  = (op == OP_STO);
      jmp  = (op == OP_JMP);
      hlt  = (op == OP_HLT);
      skip = (op == OP_SKZ) && zx;
      if (hlt) begin
         e_rd   = (c <= 2);
         e_ir   = (c <= 2);
         e_inc  = (c == 2);
         e_halt = (c >= 4);
         return {1'b0, e_rd, 1'b0, e_ir, e_inc, 1'b0, 1'b0, 1'b0, e_halt};
      end
      e_ir  = (c <= 2);
      e_rd  = (c <= 2) || (alu && c >= 5 && c <= 7);
      e_inc = (c == 2) || (c == 4) || (skip && (c == 6 || c == 7));
      e_alu = alu && (c == 6);
      e_acc = alu && (c == 7);
      e_dc  = sto && (c >= 5 && c <= 7);
      e_wr  = sto && (c == 6);
      e_pc  = jmp && (c == 6 || c == 7);
      return {e_alu, e_rd, e_wr, e_ir, e_inc, e_pc, e_acc, e_dc, 1'b0};
   endfunction

   // One clock: queue the expectation for the cycle after the next edge.
   task automatic step(input logic [8:0] exp);
      exp_q.push_back(exp);
      @(negedge clk);
      #1;
   endtask

   // Idle cycles at the boundary with ena low (or stuck in HALTED).
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         ena    = 1'b0;
         opcode = 3'($urandom_range(0, 7));
         zero   = 1'($urandom_range(0, 1));
         step(halted ? 9'b0_0000_0001 : 9'b0);
      end
   endtask

   // Run the first ncyc cycles of one instruction. The opcode is valid only
   // around DECODE and zero only at EXEC; elsewhere both are random noise,
   // and zero at MEM is the inverse of its EXEC value.
   task automatic do_instr(input opcode_e op, input logic zx, input int ncyc);
      for (int c = 1; c <= ncyc; c++) begin
         ena    = (c == 1) ? 1'b1 : 1'($urandom_range(0, 1));
         opcode = (c == 4 || c == 5) ? 3'(op) : 3'($urandom_range(0, 7));
         zero   = (c == 6) ? zx : ((c == 7) ? ~zx : 1'($urandom_range(0, 1)));
         step(model(op, zx, c));
      end
      if (op == OP_HLT) halted = 1'b1;
   endtask

   // Scoreboard monitor: one expectation per cycle, sampled mid-cycle.
   always @(negedge clk) begin
      cyc++;
      if (exp_q.size() != 0) begin
         mon_exp = exp_q.pop_front();
         check($sformatf("strobes_c%0d", cyc), dut_out, mon_exp);
      end
      check("rd_wr_exclusive", {8'b0, rd & wr}, 9'b0);
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset  = 1'b0;
      ena    = 1'b0;
      opcode = 3'b000;
      zero   = 1'b0;
      #1;
      check("reset_outputs_no_clk", dut_out, 9'b0);
      @(negedge clk);
      #1;
      check("reset_outputs_after_clk", dut_out, 9'b0);
      reset = 1'b1;
      idle(2);

      // Directed instructions.
      do_instr(OP_ADD, 1'b0, 8);
      do_instr(OP_STO, 1'b1, 8);
      do_instr(OP_SKZ, 1'b1, 8);
      do_instr(OP_SKZ, 1'b0, 8);
      do_instr(OP_JMP, 1'b0, 8);
      idle(3);

      // Reset dropped during MEM of STO: strobes drop without a clock.
      do_instr(OP_STO, 1'b0, 6);
      reset = 1'b0;
      #1;
      check("sto_abort_async", dut_out, 9'b0);
      halted = 1'b0;
      idle(2);
      reset = 1'b1;
      idle(4);
      do_instr(OP_LDA, 1'b1, 8);

      // Random instruction mix with random boundary gaps.
      for (int i = 0; i < 60; i++) begin
         do_instr(opcode_e'(3'($urandom_range(1, 7))), 1'($urandom_range(0, 1)), 8);
         idle($urandom_range(0, 2));
      end

      // Halt, stay halted, then restart through reset.
      do_instr(OP_HLT, 1'b0, 8);
      idle(20);
      reset = 1'b0;
      #1;
      check("halt_reset_async", dut_out, 9'b0);
      halted = 1'b0;
      #1;
      reset = 1'b1;
      do_instr(OP_XORR, 1'b0, 8);
      do_instr(OP_ANDD, 1'b1, 8);

      check("scoreboard_drained", 9'(exp_q.size()), 9'b0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
